mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- MEM-stage initiator for the 16-bit pipelined CPU. It is the requesting side of the data-RAM interface.
- Accepts one load, store or pass-through op at a time from the EX/MEM register and drives the RAM address, read strobe, write strobe and write data.
- Returns the load data or the ALU result to writeback through a valid/ready handshake, and raises `stall` while busy.
- Supports a programmable number of RAM wait states, so slower memories need no pipeline changes.

Parameters:
- `WAIT_STATES`, default 0: extra ACCESS cycles before the data is sampled or the write is issued; valid range 0..15.
- `ADDR_MAX`, default 16'h00FF: highest legal word address; anything above it faults.

Ports:
- `clk`  in  1: clock; all state changes on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `req_valid`  in  1: request present.
- `req_ready`  out  1: unit can accept a request; high only in IDLE.
- `req_addr`  in  16: memory address, or the ALU result for a pass-through op.
- `req_wdata`  in  16: store data.
- `req_is_load`  in  1: op is a load.
- `req_is_store`  in  1: op is a store.
- `req_rd`  in  3: destination register tag.
- `mem_addr`  out  16: RAM word address.
- `mem_read`  out  1: RAM read strobe.
- `mem_write`  out  1: RAM write strobe; the RAM writes on a posedge while this is high.
- `mem_wdata`  out  16: RAM write data.
- `mem_rdata`  in  16: RAM read data, combinational from `mem_addr`.
- `resp_valid`  out  1: response present.
- `resp_ready`  in  1: writeback accepts the response.
- `resp_data`  out  16: load data, ALU result, or 0.
- `resp_rd`  out  3: echoed register tag.
- `resp_wb`  out  1: register write required (loads and pass-through ops only).
- `resp_fault`  out  1: address out of range, or load and store both set.
- `stall`  out  1: equals `req_valid & ~req_ready`.

Behaviour:
- States:
  - IDLE → ACCESS (legal load or store) or RESP (pass-through or fault).
  - ACCESS → RESP when the wait counter reaches `WAIT_STATES`.
  - RESP → IDLE on `resp_ready`.
- Acceptance:
  - A request is accepted when `req_valid & req_ready`.
  - Address, wdata, rd and op type are latched at that edge.
  - Request inputs are ignored in every other state.
- Reset values:
  - State IDLE, counter 0, `req_ready`=1.
  - `mem_addr`, `mem_wdata`, `resp_data` = 0.
  - `mem_read`, `mem_write`, `resp_valid`, `resp_rd`, `resp_wb`, `resp_fault` = 0.
- Outputs outside ACCESS: `mem_addr`, `mem_wdata`, `mem_read` and `mem_write` are all 0.
- Load:
  - Throughout ACCESS: `mem_read`=1 and `mem_addr` = latched address.
  - `mem_rdata` is registered into `resp_data` at the final ACCESS edge.
  - `resp_wb`=1.
  - Latency from the accept edge to `resp_valid`: 2+`WAIT_STATES` cycles.
- Store:
  - `mem_addr` and `mem_wdata` are driven for all ACCESS cycles.
  - `mem_write`=1 only in the final ACCESS cycle, so exactly one RAM write occurs.
  - `resp_valid` carries `resp_data`=0 and `resp_wb`=0.
- Pass-through (neither load nor store):
  - No RAM strobes.
  - `resp_data` = `req_addr`, `resp_wb`=1.
  - `resp_valid` 1 cycle after accept.
- Fault:
  - Triggered when an address above `ADDR_MAX` is used by a load or store, or when load and store are both set.
  - No strobes; `resp_fault`=1, `resp_data`=0, `resp_wb`=0.
  - `resp_valid` 1 cycle after accept.
- Response handshake:
  - `resp_*` outputs are held stable while `resp_valid & ~resp_ready`.
  - On a `resp_ready` edge: `resp_valid` clears and the state returns to IDLE.
  - A new request is accepted no earlier than the following cycle.
- Counter: 4-bit wait counter; it clears on entry to ACCESS and never wraps past `WAIT_STATES`.
- Reset mid-operation: `rst` in ACCESS or RESP forces IDLE at that edge.
  - All strobes are 0 from that edge on, and no write is issued.
  - Any pending response is discarded.

Optional Feature:
- Macro `MEM_ACCESS_PERF_EN`.
- Defined:
  - Adds 16-bit outputs `load_count` and `store_count`.
  - Each increments once per completed load or store, on the edge the response is accepted.
  - Faults and pass-through ops are not counted.
  - Both counters wrap from 16'hFFFF to 0 and reset to 0.
- Undefined: neither port nor the counter logic exists; all other behaviour is identical.

Test Plan:
- Load, `WAIT_STATES`=0, addr 16'h0010, RAM[0x10]=16'hBEEF, `resp_ready`=1 → `mem_read` high exactly 1 cycle; `resp_valid` at accept+2 with `resp_data`=16'hBEEF, `resp_wb`=1.
- Store, addr 16'h0020, wdata 16'h1234, `WAIT_STATES`=3 → `mem_write` high exactly 1 cycle (4th ACCESS cycle); a follow-up load of 0x20 returns 16'h1234.
- Pass-through, addr 16'h00AB → no strobes; `resp_valid` at accept+1 with `resp_data`=16'h00AB, `resp_wb`=1.
- Load at addr 16'h0100 → `resp_fault`=1, `resp_data`=0, `mem_read` never high; load with `req_is_store`=1 also set → same fault response.
- `resp_ready` held low 5 cycles after a load → `resp_*` stable; `req_ready`=0 and `stall`=1 while `req_valid`=1.
- `rst` asserted in the final ACCESS cycle of a store → `mem_write`=0 at that edge, RAM unchanged, all outputs at reset values.

Source files
------------

// File: rtl/mem_access_unit_if.sv
// Request, RAM and response signals of the MEM-stage access unit, bundled for
// connection between the unit (master) and its pipeline/RAM surroundings (slave).
interface mem_access_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic        req_is_load;
    logic        req_is_store;
    logic [2:0]  req_rd;

    logic [15:0] mem_addr;
    logic        mem_read;
    logic        mem_write;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;

    logic        resp_valid;
    logic        resp_ready;
    logic [15:0] resp_data;
    logic [2:0]  resp_rd;
    logic        resp_wb;
    logic        resp_fault;
    logic        stall;

    modport master (
        input  req_valid, req_addr, req_wdata, req_is_load, req_is_store, req_rd,
        input  mem_rdata, resp_ready,
        output req_ready, mem_addr, mem_read, mem_write, mem_wdata,
        output resp_valid, resp_data, resp_rd, resp_wb, resp_fault, stall
    );

    modport slave (
        output req_valid, req_addr, req_wdata, req_is_load, req_is_store, req_rd,
        output mem_rdata, resp_ready,
        input  req_ready, mem_addr, mem_read, mem_write, mem_wdata,
        input  resp_valid, resp_data, resp_rd, resp_wb, resp_fault, stall
    );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage initiator: issues one load/store/pass-through op at a time to the data RAM
// with programmable wait states. Define MEM_ACCESS_PERF_EN to add load/store counters.
module mem_access_unit #(
    parameter int unsigned WAIT_STATES = 0,
    parameter logic [15:0] ADDR_MAX    = 16'h00FF
) (
    input  logic              clk,
    input  logic              rst,
    mem_access_unit_if.master bus
`ifdef MEM_ACCESS_PERF_EN
    ,
    output logic [15:0]       load_count,
    output logic [15:0]       store_count
`endif
);

    localparam logic [3:0] WaitLast = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    state_t      state;
    state_t      nextState;

    logic [15:0] addrReg;
    logic [15:0] wdataReg;
    logic [2:0]  rdReg;
    logic        isLoadReg;
    logic        isStoreReg;
    logic [3:0]  waitCount;

    logic        respValid;
    logic [15:0] respData;
    logic [2:0]  respRd;
    logic        respWb;
    logic        respFault;

    logic        reqReady;
    logic        memRead;
    logic        memWrite;
    logic [15:0] memAddr;
    logic [15:0] memWdata;

    logic        accept;
    logic        reqMemOp;
    logic        reqFault;
    logic        lastAccess;

    assign accept     = bus.req_valid && (state == IDLE);
    assign reqMemOp   = bus.req_is_load | bus.req_is_store;
    assign reqFault   = (bus.req_is_load & bus.req_is_store) |
                        (reqMemOp & (bus.req_addr > ADDR_MAX));
    assign lastAccess = (waitCount == WaitLast);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // The write strobe only rises in the final ACCESS cycle so the RAM sees exactly one write.
    always_comb begin
        nextState = state;
        reqReady  = 1'b0;
        memRead   = 1'b0;
        memWrite  = 1'b0;
        memAddr   = 16'h0000;
        memWdata  = 16'h0000;
        case (state)
            IDLE: begin
                reqReady = 1'b1;
                if (bus.req_valid) begin
                    nextState = (reqMemOp && !reqFault) ? ACCESS : RESP;
                end
            end
            ACCESS: begin
                memAddr  = addrReg;
                memRead  = isLoadReg;
                memWrite = isStoreReg & lastAccess;
                if (isStoreReg) begin
                    memWdata = wdataReg;
                end
                if (lastAccess) begin
                    nextState = RESP;
                end
            end
            RESP: begin
                if (bus.resp_ready) begin
                    nextState = IDLE;
                end
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    // Request latch, wait counter and registered response; fault and pass-through
    // responses are produced straight from the accept edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            addrReg    <= 16'h0000;
            wdataReg   <= 16'h0000;
            rdReg      <= 3'd0;
            isLoadReg  <= 1'b0;
            isStoreReg <= 1'b0;
            waitCount  <= 4'd0;
            respValid  <= 1'b0;
            respData   <= 16'h0000;
            respRd     <= 3'd0;
            respWb     <= 1'b0;
            respFault  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        addrReg    <= bus.req_addr;
                        wdataReg   <= bus.req_wdata;
                        rdReg      <= bus.req_rd;
                        isLoadReg  <= bus.req_is_load;
                        isStoreReg <= bus.req_is_store;
                        waitCount  <= 4'd0;
                        if (reqFault) begin
                            respValid <= 1'b1;
                            respData  <= 16'h0000;
                            respRd    <= bus.req_rd;
                            respWb    <= 1'b0;
                            respFault <= 1'b1;
                        end else if (!reqMemOp) begin
                            respValid <= 1'b1;
                            respData  <= bus.req_addr;
                            respRd    <= bus.req_rd;
                            respWb    <= 1'b1;
                            respFault <= 1'b0;
                        end
                    end
                end
                ACCESS: begin
                    if (lastAccess) begin
                        respValid <= 1'b1;
                        respData  <= isLoadReg ? bus.mem_rdata : 16'h0000;
                        respRd    <= rdReg;
                        respWb    <= isLoadReg;
                        respFault <= 1'b0;
                    end else begin
                        waitCount <= waitCount + 4'd1;
                    end
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        respValid <= 1'b0;
                    end
                end
                default: begin
                    respValid <= 1'b0;
                end
            endcase
        end
    end

`ifdef MEM_ACCESS_PERF_EN
    logic [15:0] loadCnt;
    logic [15:0] storeCnt;

    // Only successful memory ops count, on the edge their response is taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            loadCnt  <= 16'h0000;
            storeCnt <= 16'h0000;
        end else if ((state == RESP) && bus.resp_ready && !respFault) begin
            if (isLoadReg) begin
                loadCnt <= loadCnt + 16'h0001;
            end
            if (isStoreReg) begin
                storeCnt <= storeCnt + 16'h0001;
            end
        end
    end

    assign load_count  = loadCnt;
    assign store_count = storeCnt;
`endif

    // Strobes are gated by reset so an abort in the last ACCESS cycle never writes.
    assign bus.req_ready  = reqReady;
    assign bus.stall      = bus.req_valid & ~reqReady;
    assign bus.mem_read   = memRead & ~rst;
    assign bus.mem_write  = memWrite & ~rst;
    assign bus.mem_addr   = memAddr;
    assign bus.mem_wdata  = memWdata;
    assign bus.resp_valid = respValid;
    assign bus.resp_data  = respData;
    assign bus.resp_rd    = respRd;
    assign bus.resp_wb    = respWb;
    assign bus.resp_fault = respFault;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed and random ops against a RAM
// model plus a transaction-level reference of the expected responses.
module tb_mem_access_unit;

    localparam int          WAIT = 3;
    localparam logic [15:0] AMAX = 16'h00FF;

    logic clk = 1'b0;
    logic rst;
    int   compared   = 0;
    int   mismatched = 0;
    int   readCycles = 0;
    int   writeCycles = 0;
    int   expLoads = 0;
    int   expStores = 0;

    logic [15:0] ram    [0:255];
    logic [15:0] refRam [0:255];

    always #5 clk = ~clk;

    mem_access_unit_if bus();

`ifdef MEM_ACCESS_PERF_EN
    logic [15:0] loadCount;
    logic [15:0] storeCount;
`endif

    mem_access_unit #(
        .WAIT_STATES(WAIT),
        .ADDR_MAX(AMAX)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef MEM_ACCESS_PERF_EN
        ,
        .load_count(loadCount),
        .store_count(storeCount)
`endif
    );

    // Data RAM: combinational read, write on a posedge while the strobe is high.
    assign bus.mem_rdata = ram[bus.mem_addr[7:0]];

    always @(posedge clk) begin
        if (bus.mem_write) ram[bus.mem_addr[7:0]] <= bus.mem_wdata;
    end

    always @(posedge clk) begin
        if (bus.mem_read) readCycles++;
        if (bus.mem_write) writeCycles++;
    end

    task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One complete op: drive, measure latency, check response, hold, handshake, check strobes.
    task automatic applyStimulus(input logic ld, input logic st, input logic [15:0] addr,
                                 input logic [15:0] wdata, input logic [2:0] rd,
                                 input int hold, input bit keepValid);
        logic        fault;
        logic        memOp;
        int          expLat;
        int          n;
        int          r0;
        int          w0;
        logic [15:0] expData;
        logic        expWb;

        fault   = (ld && st) || ((ld || st) && (addr > AMAX));
        memOp   = (ld || st) && !fault;
        expLat  = memOp ? 2 + WAIT : 1;
        expData = fault ? 16'h0000 : (ld ? refRam[addr[7:0]] : (st ? 16'h0000 : addr));
        expWb   = !fault && !st;

        @(negedge clk);
        checkOutput("req_ready_idle", {15'd0, bus.req_ready}, 16'h0001);
        r0 = readCycles;
        w0 = writeCycles;
        bus.req_valid    = 1'b1;
        bus.req_is_load  = ld;
        bus.req_is_store = st;
        bus.req_addr     = addr;
        bus.req_wdata    = wdata;
        bus.req_rd       = rd;
        bus.resp_ready   = 1'b0;
        @(posedge clk);
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (!keepValid) bus.req_valid = 1'b0;
            bus.req_addr     = 16'($urandom);
            bus.req_wdata    = 16'($urandom);
            bus.req_is_load  = 1'($urandom);
            bus.req_is_store = 1'($urandom);
            bus.req_rd       = 3'($urandom);
            if (keepValid) checkOutput("stall_busy", {15'd0, bus.stall}, 16'h0001);
        end while (!bus.resp_valid && n < 40);

        checkOutput("latency", 16'(n), 16'(expLat));
        checkOutput("resp_data", bus.resp_data, expData);
        checkOutput("resp_rd", {13'd0, bus.resp_rd}, {13'd0, rd});
        checkOutput("resp_wb", {15'd0, bus.resp_wb}, {15'd0, expWb});
        checkOutput("resp_fault", {15'd0, bus.resp_fault}, {15'd0, fault});

        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            checkOutput("hold_valid", {15'd0, bus.resp_valid}, 16'h0001);
            checkOutput("hold_data", bus.resp_data, expData);
            checkOutput("hold_rd", {13'd0, bus.resp_rd}, {13'd0, rd});
            if (keepValid) begin
                checkOutput("hold_req_ready", {15'd0, bus.req_ready}, 16'h0000);
                checkOutput("hold_stall", {15'd0, bus.stall}, 16'h0001);
            end
        end

        bus.resp_ready = 1'b1;
        bus.req_valid  = 1'b0;
        @(negedge clk);
        bus.resp_ready = 1'b0;
        checkOutput("resp_valid_clear", {15'd0, bus.resp_valid}, 16'h0000);
        checkOutput("req_ready_back", {15'd0, bus.req_ready}, 16'h0001);
        checkOutput("read_cycles", 16'(readCycles - r0), (memOp && ld) ? 16'(1 + WAIT) : 16'h0000);
        checkOutput("write_cycles", 16'(writeCycles - w0), (memOp && st) ? 16'h0001 : 16'h0000);

        if (memOp && st) begin
            refRam[addr[7:0]] = wdata;
            checkOutput("ram_written", ram[addr[7:0]], wdata);
            expStores++;
        end
        if (memOp && ld) expLoads++;
    endtask

    initial begin
        logic [15:0] rAddr;
        logic        rLd;
        logic        rSt;

        for (int i = 0; i < 256; i++) begin
            ram[i]    = 16'($urandom);
            refRam[i] = ram[i];
        end
        ram[16'h10]    = 16'hBEEF;
        refRam[16'h10] = 16'hBEEF;

        rst              = 1'b1;
        bus.req_valid    = 1'b0;
        bus.req_addr     = 16'h0000;
        bus.req_wdata    = 16'h0000;
        bus.req_is_load  = 1'b0;
        bus.req_is_store = 1'b0;
        bus.req_rd       = 3'd0;
        bus.resp_ready   = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("rst_req_ready", {15'd0, bus.req_ready}, 16'h0001);
        checkOutput("rst_resp_valid", {15'd0, bus.resp_valid}, 16'h0000);
        checkOutput("rst_resp_data", bus.resp_data, 16'h0000);
        checkOutput("rst_mem_addr", bus.mem_addr, 16'h0000);
        checkOutput("rst_strobes", {14'd0, bus.mem_read, bus.mem_write}, 16'h0000);
        rst = 1'b0;

        applyStimulus(1'b1, 1'b0, 16'h0010, 16'h0000, 3'd1, 0, 1'b0);
        applyStimulus(1'b0, 1'b1, 16'h0020, 16'h1234, 3'd2, 0, 1'b0);
        applyStimulus(1'b1, 1'b0, 16'h0020, 16'h0000, 3'd3, 0, 1'b0);
        applyStimulus(1'b0, 1'b0, 16'h00AB, 16'h0000, 3'd4, 0, 1'b0);
        applyStimulus(1'b1, 1'b0, 16'h0100, 16'h0000, 3'd5, 0, 1'b0);
        applyStimulus(1'b1, 1'b1, 16'h0010, 16'h5555, 3'd6, 0, 1'b0);
        applyStimulus(1'b0, 1'b0, 16'hFFFF, 16'h0000, 3'd0, 0, 1'b0);
        applyStimulus(1'b1, 1'b0, 16'h00FF, 16'h0000, 3'd7, 5, 1'b1);

        // Abort a store in its final ACCESS cycle.
        @(negedge clk);
        bus.req_valid    = 1'b1;
        bus.req_is_load  = 1'b0;
        bus.req_is_store = 1'b1;
        bus.req_addr     = 16'h0030;
        bus.req_wdata    = ~refRam[16'h30];
        bus.req_rd       = 3'd5;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        repeat (WAIT) @(negedge clk);
        checkOutput("abort_final_write", {15'd0, bus.mem_write}, 16'h0001);
        rst = 1'b1;
        begin
            int w0;
            w0 = writeCycles;
            @(negedge clk);
            checkOutput("abort_no_write", 16'(writeCycles - w0), 16'h0000);
        end
        checkOutput("abort_ram", ram[16'h30], refRam[16'h30]);
        checkOutput("abort_mem_write", {15'd0, bus.mem_write}, 16'h0000);
        checkOutput("abort_mem_addr", bus.mem_addr, 16'h0000);
        checkOutput("abort_mem_wdata", bus.mem_wdata, 16'h0000);
        checkOutput("abort_resp_valid", {15'd0, bus.resp_valid}, 16'h0000);
        checkOutput("abort_resp_rd", {13'd0, bus.resp_rd}, 16'h0000);
        checkOutput("abort_req_ready", {15'd0, bus.req_ready}, 16'h0001);
        expLoads  = 0;
        expStores = 0;
        rst = 1'b0;

        for (int k = 0; k < 25; k++) begin
            rAddr = 16'($urandom_range(0, 16'h011F));
            rLd   = 1'($urandom);
            rSt   = 1'($urandom_range(0, 3) == 0) ? 1'b1 : (rLd ? 1'b0 : 1'($urandom));
            applyStimulus(rLd, rSt, rAddr, 16'($urandom), 3'($urandom),
                          $urandom_range(0, 2), 1'($urandom));
        end

`ifdef MEM_ACCESS_PERF_EN
        checkOutput("load_count", loadCount, 16'(expLoads));
        checkOutput("store_count", storeCount, 16'(expStores));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
